// File: rtl/spi_param_regs_pkg.sv
// Shared protocol constants for the SPI parameter register block.
// Covers the header and data word field layout, the op codes and the FSM state encoding.
package spi_param_regs_pkg;

    localparam logic [3:0] MAGIC = 4'hA;

    localparam logic [1:0] OP_WRITE   = 2'b00;
    localparam logic [1:0] OP_COMMIT  = 2'b01;
    localparam logic [1:0] OP_DISCARD = 2'b10;
    localparam logic [1:0] OP_RSVD    = 2'b11;

    localparam int MAGIC_MSB = 31;
    localparam int MAGIC_LSB = 28;
    localparam int OP_MSB    = 27;
    localparam int OP_LSB    = 26;
    localparam int ADDR_MSB  = 11;
    localparam int ADDR_LSB  = 8;
    localparam int COUNT_MSB = 7;
    localparam int COUNT_LSB = 0;
    localparam int VALUE_MSB = 31;
    localparam int VALUE_LSB = 16;
    localparam int CHECK_MSB = 15;
    localparam int CHECK_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_word_decode.sv
// Combinational field splitter for one received SPI word.
// The same word is interpreted as a header (magic/op/addr/count) and as a data word (value/check).
module spi_word_decode
    import spi_param_regs_pkg::*;
(
    input  logic [31:0] word_i,
    output logic        magic_ok_o,
    output logic [1:0]  op_o,
    output logic [3:0]  addr_o,
    output logic [7:0]  count_o,
    output logic [15:0] value_o,
    output logic        check_ok_o
);

    logic unusedBits;

    assign magic_ok_o = (word_i[MAGIC_MSB:MAGIC_LSB] == MAGIC);
    assign op_o       = word_i[OP_MSB:OP_LSB];
    assign addr_o     = word_i[ADDR_MSB:ADDR_LSB];
    assign count_o    = word_i[COUNT_MSB:COUNT_LSB];
    assign value_o    = word_i[VALUE_MSB:VALUE_LSB];
    // A data word carries its own inverted copy as a cheap integrity check.
    assign check_ok_o = (word_i[CHECK_MSB:CHECK_LSB] == ~word_i[VALUE_MSB:VALUE_LSB]);
    assign unusedBits = ^word_i[25:12];

endmodule

// File: rtl/spi_param_regs.sv
// Framed SPI protocol parser feeding staged and active PID parameter banks.
// Active values change only on COMMIT, which also raises a one-cycle update strobe.
module spi_param_regs
    import spi_param_regs_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ERR_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs,
    input  logic                    word_valid,
    input  logic [31:0]             word,
    output logic [NUM_REGS*16-1:0]  params,
    output logic                    params_update,
    output logic                    busy,
    output logic [ERR_BITS-1:0]     err_count
);

    state_t                  state_q, state_d;
    logic [3:0]              addr_q, addr_d;
    logic [7:0]              count_q, count_d;
    logic [NUM_REGS*16-1:0]  staged_q, staged_d;
    logic [NUM_REGS*16-1:0]  active_q, active_d;
    logic                    update_q, update_d;
    logic [ERR_BITS-1:0]     err_q, err_d;

    logic                    errInc;
    logic                    writeEn;
    logic                    discardEn;
    logic                    commitEn;

    logic                    decMagicOk;
    logic [1:0]              decOp;
    logic [3:0]              decAddr;
    logic [7:0]              decCount;
    logic [15:0]             decValue;
    logic                    decCheckOk;

    spi_word_decode u_decode (
        .word_i     (word),
        .magic_ok_o (decMagicOk),
        .op_o       (decOp),
        .addr_o     (decAddr),
        .count_o    (decCount),
        .value_o    (decValue),
        .check_ok_o (decCheckOk)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        errInc    = 1'b0;
        writeEn   = 1'b0;
        discardEn = 1'b0;
        commitEn  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    if (!decMagicOk || decOp == OP_RSVD) begin
                        errInc = 1'b1;
                    end else if (decOp == OP_WRITE) begin
                        if (decCount == 8'd0) begin
                            state_d = ST_IDLE;
                        end else if (int'(decAddr) >= NUM_REGS) begin
                            errInc = 1'b1;
                        end else begin
                            addr_d  = decAddr;
                            count_d = decCount;
                            state_d = ST_BURST;
                        end
                    end else if (decOp == OP_COMMIT) begin
                        commitEn = 1'b1;
                        state_d  = ST_COMMIT;
                    end else begin
                        discardEn = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (word_valid) begin
                    if (!decCheckOk) begin
                        errInc  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        writeEn = 1'b1;
                        addr_d  = (addr_q == 4'(NUM_REGS - 1)) ? 4'd0 : addr_q + 4'd1;
                        count_d = count_q - 8'd1;
                        if (count_q == 8'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                // Deselect only aborts a burst that the current word did not finish.
                if (cs && state_d == ST_BURST) begin
                    errInc  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (word_valid) begin
                    errInc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        staged_d = staged_q;
        if (discardEn) begin
            staged_d = active_q;
        end else if (writeEn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 4'(i)) begin
                    staged_d[16*i +: 16] = decValue;
                end
            end
        end
    end

    // The copy is taken on the header edge so params and the strobe appear together in the COMMIT cycle.
    always_comb begin
        active_d = commitEn ? staged_q : active_q;
        update_d = commitEn;
        err_d    = err_q;
        if (errInc && err_q != '1) begin
            err_d = err_q + ERR_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            staged_q <= '0;
            active_q <= '0;
            update_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            staged_q <= staged_d;
            active_q <= active_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    assign params        = active_q;
    assign params_update = update_q;
    assign busy          = (state_q != ST_IDLE);
    assign err_count     = err_q;

endmodule
